// File: rtl/seg7_scan_ctrl_if.sv
// Bus between a value producer and the 4-digit 7-segment scan controller.
// Handshake: the producer raises load with din valid; the value is accepted
// on any rising edge where load=1 and busy=0 (busy acts as an inverted
// ready). While busy=1 load is ignored. ack pulses for one cycle when the
// accepted value becomes the displayed value; busy drops the cycle after.
interface seg7_scan_ctrl_if;
  logic        load;
  logic [15:0] din;
  logic        busy;
  logic        ack;
  logic [3:0]  cntl;
  logic [3:0]  an;
  logic        frame;
  logic        dbg_state;

  modport master (
    output load, din,
    input  busy, ack, cntl, an, frame, dbg_state
  );

  modport slave (
    input  load, din,
    output busy, ack, cntl, an, frame, dbg_state
  );
endinterface

// File: rtl/seg7_scan_ctrl.sv
// Time-multiplexed 4-digit 7-segment scan controller with tear-free update.
// Each digit slot lasts DIV cycles; the first GAP cycles of a slot are blank
// to avoid ghosting. New values are swapped in only at the start of digit0.
// Optional feature: define SEG7_LZB_EN to blank leading zeros (digit0 never).
module seg7_scan_ctrl #(
  parameter int DIV = 50000,
  parameter int GAP = 16
) (
  input logic             clk,
  input logic             rst,
  seg7_scan_ctrl_if.slave bus
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST     = CW'(DIV - 1);
  localparam logic [CW-1:0] CNT_GAP_LAST = CW'(GAP - 1);

  typedef enum logic {
    BLANK = 1'b0,
    DRIVE = 1'b1
  } state_t;

  state_t        state, state_next;
  logic [CW-1:0] cnt, cnt_next;
  logic [1:0]    idx, idx_next;
  logic          cnt_wrap;

  logic [15:0]   pend_reg, pend_next;
  logic [15:0]   disp_reg, disp_next;
  logic          busy_reg, busy_next;
  logic          ack_reg, ack_next;
  logic          frame_reg, frame_next;
  logic [3:0]    an_reg, an_next;
  logic [3:0]    cntl_reg, cntl_next;
  logic [3:0]    nib;
  logic          xfer;
`ifdef SEG7_LZB_EN
  logic          lead_zero;
`endif

  // ack marks the transfer cycle itself: first BLANK cycle of digit0 with a value pending.
  assign xfer = ack_reg;

  // Next-state logic; outputs are computed from next-cycle position so the
  // registered outputs line up with the state they belong to.
  always_comb begin
    state_next = state;
    cnt_wrap   = (cnt == CNT_LAST);
    cnt_next   = cnt_wrap ? '0 : cnt + 1'b1;
    idx_next   = cnt_wrap ? idx + 2'd1 : idx;

    case (state)
      BLANK:   if (cnt == CNT_GAP_LAST) state_next = DRIVE;
      DRIVE:   if (cnt_wrap)            state_next = BLANK;
      default:                          state_next = BLANK;
    endcase

    disp_next  = xfer ? pend_reg : disp_reg;
    pend_next  = (bus.load && !busy_reg) ? bus.din : pend_reg;
    busy_next  = xfer ? 1'b0 : (busy_reg | bus.load);
    ack_next   = busy_next && (cnt_next == '0) && (idx_next == 2'd0);
    frame_next = (idx_next == 2'd3) && (cnt_next == CNT_LAST);

    nib = disp_next[{idx_next, 2'b00} +: 4];
`ifdef SEG7_LZB_EN
    lead_zero = 1'b0;
    case (idx_next)
      2'd3:    lead_zero = (disp_next[15:12] == 4'd0);
      2'd2:    lead_zero = (disp_next[15:8]  == 8'd0);
      2'd1:    lead_zero = (disp_next[15:4]  == 12'd0);
      default: lead_zero = 1'b0;
    endcase
    if (lead_zero) nib = 4'hF;
`endif

    an_next   = 4'b1111;
    cntl_next = 4'hF;
    if (state_next == DRIVE) begin
      an_next   = ~(4'b0001 << idx_next);
      cntl_next = nib;
    end
  end

  // State, counters, value registers and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= BLANK;
      cnt       <= '0;
      idx       <= 2'd0;
      pend_reg  <= 16'd0;
      disp_reg  <= 16'd0;
      busy_reg  <= 1'b0;
      ack_reg   <= 1'b0;
      frame_reg <= 1'b0;
      an_reg    <= 4'b1111;
      cntl_reg  <= 4'hF;
    end else begin
      state     <= state_next;
      cnt       <= cnt_next;
      idx       <= idx_next;
      pend_reg  <= pend_next;
      disp_reg  <= disp_next;
      busy_reg  <= busy_next;
      ack_reg   <= ack_next;
      frame_reg <= frame_next;
      an_reg    <= an_next;
      cntl_reg  <= cntl_next;
    end
  end

  assign bus.busy      = busy_reg;
  assign bus.ack       = ack_reg;
  assign bus.frame     = frame_reg;
  assign bus.an        = an_reg;
  assign bus.cntl      = cntl_reg;
  assign bus.dbg_state = state;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Self-checking bench for seg7_scan_ctrl (DIV=8, GAP=2). A position-based
// model (cycle index within a 4*DIV frame) predicts every output each cycle.
module tb_seg7_scan_ctrl;
  localparam int DIV = 8;
  localparam int GAP = 2;
  localparam int FR  = 4 * DIV;

  logic clk = 1'b0;
  logic rst;
  seg7_scan_ctrl_if bus ();

  seg7_scan_ctrl #(.DIV(DIV), .GAP(GAP)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // clock / reset
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // reference model: frame position, displayed value, pending values
  int          m_pos  = 0;
  logic [15:0] m_disp = 16'd0;
  logic [15:0] exp_q[$];

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [3:0] exp_code(input int d, input logic [15:0] v);
    int val;
    val = (v >> (4 * d)) % 16;
`ifdef SEG7_LZB_EN
    if (d > 0 && (v >> (4 * d)) == 16'd0) return 4'hF;
`endif
    return val[3:0];
  endfunction

  task automatic check_outputs();
    int d, c;
    logic drive, pending;
    logic [3:0] e_an, e_cntl;
    d = m_pos / DIV;
    c = m_pos % DIV;
    drive   = (c >= GAP);
    pending = (exp_q.size() != 0);
    e_an    = drive ? 4'(15 - (2 ** d)) : 4'hF;
    e_cntl  = drive ? exp_code(d, m_disp) : 4'hF;
    chk("an",    {12'd0, bus.an},        {12'd0, e_an});
    chk("cntl",  {12'd0, bus.cntl},      {12'd0, e_cntl});
    chk("busy",  {15'd0, bus.busy},      {15'd0, pending});
    chk("ack",   {15'd0, bus.ack},       {15'd0, pending && m_pos == 0});
    chk("frame", {15'd0, bus.frame},     {15'd0, 1'(m_pos == FR - 1)});
    chk("state", {15'd0, bus.dbg_state}, {15'd0, drive});
  endtask

  // driver: check the current cycle, apply inputs for the next edge, advance model
  task automatic cyc(input logic r, input logic ld, input logic [15:0] d);
    @(negedge clk);
    check_outputs();
    rst      = r;
    bus.load = ld;
    bus.din  = d;
    if (r) begin
      m_pos  = 0;
      m_disp = 16'd0;
      exp_q.delete();
    end else begin
      if (exp_q.size() != 0 && m_pos == 0) m_disp = exp_q.pop_front();
      else if (ld && exp_q.size() == 0)    exp_q.push_back(d);
      m_pos = (m_pos + 1) % FR;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 16'($urandom));
  endtask

  task automatic run_to(input int p);
    for (int i = 0; i < FR && m_pos != p; i++) cyc(1'b0, 1'b0, 16'd0);
  endtask

  initial begin
    rst      = 1'b1;
    bus.load = 1'b0;
    bus.din  = 16'd0;

    // reset held three cycles
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 16'd0);

    // basic load and scan
    cyc(1'b0, 1'b1, 16'h4321);
    idle(2 * FR + 2);

    // load mid-DRIVE of digit2
    run_to(2 * DIV + GAP + 1);
    cyc(1'b0, 1'b1, 16'h5678);
    idle(FR + 2);

    // load while busy is ignored
    cyc(1'b0, 1'b1, 16'h1234);
    cyc(1'b0, 1'b1, 16'h9999);
    idle(FR + 2);

    // leading zeros
    cyc(1'b0, 1'b1, 16'h0070);
    idle(FR + 2);

    // reset during DRIVE of digit2 with a value pending
    run_to(2 * DIV);
    cyc(1'b0, 1'b1, 16'h8888);
    run_to(2 * DIV + GAP + 1);
    cyc(1'b1, 1'b0, 16'd0);
    idle(FR + 2);

    // load landing exactly on the transfer cycle is ignored
    cyc(1'b0, 1'b1, 16'h2468);
    run_to(0);
    cyc(1'b0, 1'b1, 16'hABCD);
    idle(FR + 2);

    // randomized traffic, including non-BCD nibbles and occasional reset
    for (int i = 0; i < 3000; i++) begin
      cyc(1'($urandom_range(0, 199) == 0),
          1'($urandom_range(0, 7) == 0),
          16'($urandom));
    end
    idle(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/seg7_scan_ctrl.md
SEG7_SCAN_CTRL -- requirements
Module: seg7_scan_ctrl

Interface
REQ-001 SHALL provide parameter DIV, default 50000: clock cycles per digit slot.
REQ-002 SHALL provide parameter GAP, default 16: blanking cycles at the start of each slot; legal range 1 <= GAP < DIV.
REQ-003 SHALL provide port clk, input, 1 bit: single clock; all logic rising-edge.
REQ-004 SHALL provide port rst, input, 1 bit: reset, synchronous, active-high.
REQ-005 SHALL provide port load, input, 1 bit: request to latch din.
REQ-006 SHALL provide port din, input, 16 bits: four BCD digits; [3:0] = digit0 (rightmost) ... [15:12] = digit3.
REQ-007 SHALL provide port busy, output, 1 bit: a latched value is pending, not yet displayed.
REQ-008 SHALL provide port ack, output, 1 bit: one-cycle pulse when the pending value becomes the displayed value.
REQ-009 SHALL provide port cntl, output, 4 bits: code to the shared 7-segment decoder; 4'hF = blank, since the decoder turns all segments off for codes 10-15.
REQ-010 SHALL provide port an, output, 4 bits: active-low one-hot digit enable; bit n = digit n.
REQ-011 SHALL provide port frame, output, 1 bit: one-cycle pulse at end of frame.

Function
REQ-012 SHALL keep slot counter cnt (0..DIV-1), wrapping to 0 after DIV-1, and digit index idx (0..3), incrementing on cnt wrap, 3 -> 0.
REQ-013 SHALL implement FSM {BLANK, DRIVE}: BLANK for cnt 0..GAP-1, DRIVE for cnt GAP..DIV-1; DRIVE -> BLANK on cnt wrap.
REQ-014 SHALL register all outputs; in BLANK: an=4'b1111, cntl=4'hF.
REQ-015 SHALL in DRIVE: an = ~(4'b0001 << idx), cntl = disp_reg nibble idx.
REQ-016 SHALL pass invalid BCD nibbles (A-F) through unchanged, so the decoder blanks them.
REQ-017 SHALL, when load=1 and busy=0, capture din into pend_reg and set busy=1 the next cycle.
REQ-018 SHALL ignore load while busy=1: no capture, no ack.
REQ-019 SHALL copy pend_reg to disp_reg on the first cycle of BLANK with idx=0 while busy=1, assert ack that cycle, and clear busy the next cycle, so no frame tears.
REQ-020 SHALL ignore a load coinciding with the transfer cycle, since busy is still 1.
REQ-021 SHALL pulse frame on the cycle with idx=3 and cnt=DIV-1.
REQ-022 SHALL give a frame period of exactly 4*DIV cycles and a load-to-display latency of at most 4*DIV+1 cycles.

Reset
REQ-023 SHALL on rst=1 set an=4'b1111, cntl=4'hF, busy=0, ack=0, frame=0, disp_reg=0, pend_reg=0, cnt=0, idx=0, state=BLANK.
REQ-024 SHALL let rst take priority over load and scanning at any point, including mid-DRIVE and mid-pending; the pending value is discarded.
REQ-025 SHALL restart scanning on the first cycle after rst deasserts, with GAP cycles of BLANK on digit0.

Configuration
REQ-026 SHALL, with macro SEG7_LZB_EN defined, blank leading zeros: in DRIVE, cntl=4'hF for digit n (n=3..1) when nibble n and all higher nibbles are 0; an still asserts; digit0 is never blanked.
REQ-027 SHALL, without SEG7_LZB_EN, display every nibble as-is, with no blanking logic present.

Verification (DIV=8, GAP=2)
REQ-028 SHALL cover: rst held 3 cycles -> an=1111, cntl=F, busy=0, ack=0, frame=0 throughout.
REQ-029 SHALL cover: load 16'h4321 -> after transfer, per slot 2 blank cycles then 6 cycles of an/cntl = 1110/1, 1101/2, 1011/3, 0111/4; frame pulse every 32 cycles.
REQ-030 SHALL cover: load 16'h5678 during DRIVE of digit2 -> busy=1 next cycle; old value shown through digit3; ack=1 on first BLANK cycle of digit0; busy=0 next cycle.
REQ-031 SHALL cover: load 16'h9999 while busy from prior load of 16'h1234 -> 1234 displayed, exactly one ack.
REQ-032 SHALL cover: load 16'h0070 -> with SEG7_LZB_EN, cntl per digit 3..0 = F,F,7,0; without it, 0,0,7,0.
REQ-033 SHALL cover: rst pulse during DRIVE of digit2 with busy=1 -> next cycle an=1111, busy=0, disp_reg=0; scan restarts at digit0 with cntl=0.
